dma_engine: RTL and testbench

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine.sv | 152 +++++++++++++++
 tb/tb_dma_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_engine
//  Description : Single-channel word DMA between a streaming source/sink and
//                a byte-addressed data memory, started by a rising edge of
//                the start bit in the processor-driven command word.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_engine #(
    parameter int          N          = 32,
    parameter logic [31:0] ADDR_LIMIT = 32'h3D08F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cmd,
    input  logic [N-1:0] src_data,
    input  logic         src_valid,
    output logic         src_ready,
    output logic [N-1:0] snk_data,
    output logic         snk_valid,
    input  logic         snk_ready,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_data,
    output logic         mem_wen,
    input  logic [N-1:0] mem_rdata,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [11:0]  count
);

    localparam logic [N-1:0] c_addr_limit = N'(ADDR_LIMIT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        XFER_IN  = 3'd1,
        XFER_OUT = 3'd2,
        FIN      = 3'd3,
        FAULT    = 3'd4
    } state_t;

    state_t       r_state;
    logic         r_start_q;
    logic [N-1:0] r_base;
    logic [11:0]  r_len;
    logic [11:0]  r_count;
    logic         r_error;
    logic         r_done;
    logic         r_busy;

    logic         w_start;
    logic [N-1:0] w_cmd_base;
    logic [N-1:0] w_addr;
    logic         w_in_range;
    logic         w_xfer_in;
    logic         w_xfer_out;
    logic         w_beat;
    logic [11:0]  w_count_inc;

    // Start is a rising edge of cmd[31]; a held level never retriggers.
    assign w_start     = cmd[31] & ~r_start_q;
    assign w_cmd_base  = N'(cmd[29:12]);

    // Current address is base plus one word per completed beat.
    assign w_addr      = r_base + (N'(r_count) << 2);
    assign w_in_range  = (w_addr <= c_addr_limit);
    assign w_xfer_in   = (r_state == XFER_IN);
    assign w_xfer_out  = (r_state == XFER_OUT);
    assign w_beat      = (w_xfer_in & src_valid) | (w_xfer_out & snk_ready);
    assign w_count_inc = r_count + 12'd1;

    // Handshakes are combinational so the first beat can happen on the very
    // cycle a transfer state is entered; reset suppresses them immediately so
    // an abort cannot let one more write slip through.
    assign src_ready   = w_xfer_in  & w_in_range & ~rst;
    assign snk_valid   = w_xfer_out & w_in_range & ~rst;
    assign mem_wen     = src_ready & src_valid;
    assign mem_address = (w_xfer_in | w_xfer_out) ? w_addr : '0;
    assign mem_data    = w_xfer_in  ? src_data  : '0;
    assign snk_data    = w_xfer_out ? mem_rdata : '0;

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;
    assign count = r_count;

    // Transfer control: command capture, beat counting and termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_base    <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_start_q <= cmd[31];
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_base  <= w_cmd_base;
                        r_len   <= cmd[11:0];
                        r_count <= '0;
                        r_error <= 1'b0;
                        if (cmd[11:0] == 12'd0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else if (w_cmd_base > c_addr_limit) begin
                            r_state <= FAULT;
                        end else if (cmd[30]) begin
                            r_state <= XFER_OUT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= XFER_IN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                XFER_IN, XFER_OUT: begin
                    if (!w_in_range) begin
                        r_state <= FAULT;
                        r_busy  <= 1'b0;
                    end else if (w_beat) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_len) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                FAULT: begin
                    // Flag becomes visible as the engine returns to IDLE.
                    r_error <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_engine
//  Description : Scoreboard bench for dma_engine; a queue-based reference
//                model predicts memory writes, sink beats and completion.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_engine;

    localparam int          N     = 32;
    localparam logic [31:0] LIMIT = 32'h3D08F;
    localparam int K_WR    = 0;
    localparam int K_RD    = 1;
    localparam int K_DONE  = 2;
    localparam int K_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] count;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] src_words[$];
    int          wr_log[$];
    int          done_log[$];
    logic [31:0] env_mem [0:65535];
    logic [31:0] ref_mem [0:65535];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          start_cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_engine #(.N(N), .ADDR_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .snk_data   (snk_data),
        .snk_valid  (snk_valid),
        .snk_ready  (snk_ready),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .count      (count)
    );

    // Environment data memory: combinational read, write at clock edge.
    assign mem_rdata = env_mem[mem_address[17:2]];
    always @(posedge clk) if (mem_wen) env_mem[mem_address[17:2]] <= mem_data;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input int kind, input string name, output exp_t e, output bit ok);
        vectors++;
        ok = 1'b0;
        e.kind = -1; e.addr = '0; e.data = '0;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s actual=event required=no_event (cycle %0d)", name, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                miscompares++;
                $display("FAIL %s actual_kind=%0d required_kind=%0d (cycle %0d)", name, kind, e.kind, cyc);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Reference model: the sequence of observable events a command produces.
    task automatic plan(input bit dir, input logic [31:0] base, input int len,
                        output int exp_cnt, output bit exp_fault);
        logic [31:0] a;
        exp_cnt   = len;
        exp_fault = 1'b0;
        if (len == 0) begin
            push_exp(K_DONE, '0, 32'd0);
        end else if (base > LIMIT) begin
            exp_cnt = 0; exp_fault = 1'b1;
            push_exp(K_FAULT, '0, 32'd0);
        end else begin
            for (int i = 0; i < len; i++) begin
                a = base + 32'(4 * i);
                if (a > LIMIT) begin
                    exp_cnt = i; exp_fault = 1'b1;
                    push_exp(K_FAULT, '0, 32'(i));
                    return;
                end
                if (!dir) begin
                    push_exp(K_WR, a, src_words[i]);
                    ref_mem[a[17:2]] = src_words[i];
                end else begin
                    push_exp(K_RD, a, ref_mem[a[17:2]]);
                end
            end
            push_exp(K_DONE, '0, 32'(len));
        end
    endtask

    // Issue one command and drive the source/sink until its events retire.
    task automatic run_cmd(input bit dir, input logic [31:0] base, input int len,
                           input int src_pct, input int snk_pct, input int snk_delay,
                           input bit hold);
        int          idx;
        int          exp_cnt;
        bit          exp_fault;
        bit          fin;
        logic [11:0] l12;
        idx = 0;
        fin = 1'b0;
        l12 = len[11:0];
        if (src_words.size() != len) begin
            src_words.delete();
            for (int i = 0; i < len; i++) src_words.push_back($urandom);
        end
        @(negedge clk);
        cmd = '0; src_valid = 1'b0; snk_ready = 1'b0;
        plan(dir, base, len, exp_cnt, exp_fault);
        wr_log.delete(); done_log.delete();
        @(negedge clk);
        cmd = {1'b1, dir, base[17:0], l12};
        start_cyc = cyc;
        for (int t = 0; t < 400 && !fin; t++) begin
            if (t > 0) begin
                @(negedge clk);
                if (!hold) cmd[31] = 1'b0;
            end
            src_valid = ($urandom_range(0, 99) < src_pct);
            src_data  = (idx < len) ? src_words[idx] : $urandom;
            snk_ready = (t >= snk_delay) && ($urandom_range(0, 99) < snk_pct);
            #1;
            if (src_valid && src_ready) idx++;
            #2;
            if (t > 0 && exp_q.size() == 0 && !busy) fin = 1'b1;
        end
        src_valid = 1'b0;
        snk_ready = 1'b0;
        src_words.delete();
        if (!fin) begin
            vectors++; miscompares++;
            $display("FAIL cmd_timeout actual=%0d_pending required=0 (base %h)", exp_q.size(), base);
            exp_q.delete();
        end
        chk("final_count", 32'(count), 32'(exp_cnt));
        chk("final_error", 32'(error), 32'(exp_fault));
    endtask

    // Monitor: retire expected events as the DUT presents them.
    initial begin : monitor
        exp_t e;
        bit   ok;
        bit   err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                err_prev = 1'b0;
            end else begin
                if (mem_wen) begin
                    expect_event(K_WR, "mem_write", e, ok);
                    if (ok) begin
                        chk("wr_addr", mem_address, e.addr);
                        chk("wr_data", mem_data, e.data);
                    end
                    wr_log.push_back(cyc);
                end
                if (snk_valid) begin
                    if (snk_ready) begin
                        expect_event(K_RD, "snk_beat", e, ok);
                        if (ok) begin
                            chk("rd_addr", mem_address, e.addr);
                            chk("rd_data", snk_data, e.data);
                        end
                    end else if (exp_q.size() != 0 && exp_q[0].kind == K_RD) begin
                        chk("snk_hold_data", snk_data, exp_q[0].data);
                    end else begin
                        vectors++; miscompares++;
                        $display("FAIL snk_valid actual=1 required=0 (cycle %0d)", cyc);
                    end
                end
                if (done) begin
                    expect_event(K_DONE, "done_pulse", e, ok);
                    if (ok) chk("done_count", 32'(count), e.data);
                    done_log.push_back(cyc);
                end
                if (error && !err_prev) begin
                    expect_event(K_FAULT, "fault", e, ok);
                    if (ok) chk("fault_count", 32'(count), e.data);
                end
                err_prev = error;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] r_base;
    int          r_len;
    int          r_sel;
    bit          r_dir;

    initial begin : stimulus
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        rst = 1'b1; cmd = '0; src_data = '0; src_valid = 1'b0; snk_ready = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_error", 32'(error), 32'd0);
        chk("idle_src_ready", 32'(src_ready), 32'd0);

        // Full-rate write of three words.
        src_words = '{32'hA, 32'hB, 32'hC};
        run_cmd(1'b0, 32'h100, 3, 100, 100, 0, 1'b0);
        chk("wr_mem_100", env_mem[32'h100 >> 2], 32'hA);
        chk("wr_mem_104", env_mem[32'h104 >> 2], 32'hB);
        chk("wr_mem_108", env_mem[32'h108 >> 2], 32'hC);
        chk("wr_log_size", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3 && done_log.size() == 1) begin
            chk("first_write_latency", 32'(wr_log[0]), 32'(start_cyc + 1));
            chk("write_1_back_to_back", 32'(wr_log[1]), 32'(wr_log[0] + 1));
            chk("write_2_back_to_back", 32'(wr_log[2]), 32'(wr_log[1] + 1));
            chk("done_after_last", 32'(done_log[0]), 32'(wr_log[2] + 1));
        end

        // Read with sink stalling for two transfer cycles.
        run_cmd(1'b1, 32'h200, 2, 0, 100, 3, 1'b0);
        chk("rd_done_once", 32'(done_log.size()), 32'd1);

        // Zero-length command.
        run_cmd(1'b0, 32'h500, 0, 100, 100, 0, 1'b0);
        chk("len0_done_once", 32'(done_log.size()), 32'd1);
        if (done_log.size() == 1) chk("len0_latency", 32'(done_log[0]), 32'(start_cyc + 1));

        // Range fault mid-transfer, then a held start bit must not retrigger.
        run_cmd(1'b0, 32'h3D088, 4, 100, 100, 0, 1'b1);
        chk("fault_no_done", 32'(done_log.size()), 32'd0);
        repeat (10) begin
            @(negedge clk);
            #3;
            chk("held_start_busy", 32'(busy), 32'd0);
            chk("held_start_error", 32'(error), 32'd1);
        end
        run_cmd(1'b1, 32'h300, 3, 0, 80, 0, 1'b0);

        // Reset after the first of four beats.
        @(negedge clk);
        cmd = '0;
        push_exp(K_WR, 32'h400, 32'hDEAD0001);
        ref_mem[32'h400 >> 2] = 32'hDEAD0001;
        @(negedge clk);
        cmd = {1'b1, 1'b0, 18'h400, 12'd4};
        src_valid = 1'b1;
        src_data  = 32'hDEAD0001;
        @(negedge clk);
        cmd[31] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        src_data = 32'hDEAD0002;
        @(negedge clk);
        rst = 1'b0;
        src_valid = 1'b0;
        #3;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_wen", 32'(mem_wen), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #3;
        chk("abort_no_second_write", env_mem[32'h404 >> 2], ref_mem[32'h404 >> 2]);
        exp_q.delete();

        // Randomized commands across the address space.
        for (int k = 0; k < 40; k++) begin
            r_dir = 1'($urandom_range(0, 1));
            r_sel = $urandom_range(0, 9);
            r_len = (r_sel == 0) ? 0 : $urandom_range(1, 10);
            if (r_sel <= 6)
                r_base = 32'($urandom_range(0, 32'h3C000)) & ~32'd3;
            else if (r_sel <= 8)
                r_base = (LIMIT - 32'($urandom_range(0, 40))) & ~32'd3;
            else
                r_base = 32'($urandom_range(32'h3D090, 32'h3FFFC)) & ~32'd3;
            run_cmd(r_dir, r_base, r_len, 70, 70, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
